// File: rtl/mac_accumulator.sv
// mac_accumulator
// Accumulate stage fed by the small multiplier. A job begins with a start pulse in IDLE. The
// stage then sums exactly N unsigned products, taken over a valid/ready handshake, into an
// AW-bit register that wraps modulo 2^AW. After the Nth product it pulses done for one cycle.
// ovf is sticky for the whole job and records any carry out of bit AW-1. abort cancels the job
// at the next clock edge.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   start     begin a job (only honoured in IDLE)
//   abort     synchronous cancel, wins over start and over an accept
//   prod      unsigned product, PW bits
//   in_valid  prod is valid this cycle
//   in_ready  product is accepted this cycle (ACC state)
//   acc_out   running / final sum, registered
//   busy      job in progress (ACC state)
//   done      one-cycle completion pulse (DONE state)
//   ovf       sticky overflow for the current job
module mac_accumulator #(
  parameter int unsigned PW = 4,
  parameter int unsigned AW = 12,
  parameter int unsigned N  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [PW-1:0] prod,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] acc_out,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

  localparam int unsigned CW = (N + 1 <= 2) ? 1 : $clog2(N + 1);
  localparam logic [CW-1:0] LastCount = CW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StDone
  } state_e;

  state_e        state;
  logic [CW-1:0] count;
  logic [AW:0]   sum;
  logic          accept;

  // The extra top bit of the sum is the carry out of bit AW-1.
  always_comb begin
    sum = {1'b0, acc_out} + {{(AW + 1 - PW){1'b0}}, prod};
  end

  assign accept = in_valid && (state == StAcc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StIdle;
      acc_out <= '0;
      ovf     <= 1'b0;
      count   <= '0;
    end else if (abort) begin
      // The partial sum and any product presented this cycle are dropped.
      state   <= StIdle;
      acc_out <= '0;
      ovf     <= 1'b0;
      count   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            state   <= StAcc;
            acc_out <= '0;
            ovf     <= 1'b0;
            count   <= '0;
          end
        end
        StAcc: begin
          if (accept) begin
            acc_out <= sum[AW-1:0];
            ovf     <= ovf | sum[AW];
            if (count == LastCount) begin
              count <= '0;
              state <= StDone;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  // Outputs are decoded purely from the registered state.
  assign in_ready = (state == StAcc);
  assign busy     = (state == StAcc);
  assign done     = (state == StDone);

endmodule

// File: tb/tb_mac_accumulator.sv
module tb_mac_accumulator;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        in_valid;
  logic [3:0]  prod;

  // Default instance (PW=4, AW=12, N=8)
  logic        rdy_a;
  logic [11:0] acc_a;
  logic        busy_a;
  logic        done_a;
  logic        ovf_a;

  // Narrow accumulator (AW=6, N=8)
  logic        rdy_w;
  logic [5:0]  acc_w;
  logic        busy_w;
  logic        done_w;
  logic        ovf_w;

  // Single-product job (N=1)
  logic        rdy_n;
  logic [11:0] acc_n;
  logic        busy_n;
  logic        done_n;
  logic        ovf_n;

  int checks = 0;
  int errors = 0;

  mac_accumulator #(.PW(4), .AW(12), .N(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .prod(prod), .in_valid(in_valid),
    .in_ready(rdy_a), .acc_out(acc_a), .busy(busy_a), .done(done_a), .ovf(ovf_a)
  );

  mac_accumulator #(.PW(4), .AW(6), .N(8)) dut_w (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .prod(prod), .in_valid(in_valid),
    .in_ready(rdy_w), .acc_out(acc_w), .busy(busy_w), .done(done_w), .ovf(ovf_w)
  );

  mac_accumulator #(.PW(4), .AW(12), .N(1)) dut_n (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .prod(prod), .in_valid(in_valid),
    .in_ready(rdy_n), .acc_out(acc_n), .busy(busy_n), .done(done_n), .ovf(ovf_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        ab;
    logic        vl;
    logic [3:0]  pr;
    logic [11:0] acc;
    logic        dn;
    logic        bs;
    logic        rd;
    logic        ov;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 ns after the following rising edge.
  task automatic step(input logic s, input logic a, input logic v, input logic [3:0] p);
    @(negedge clk);
    start    = s;
    abort    = a;
    in_valid = v;
    prod     = p;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string name, input logic [11:0] acc, input logic dn, input logic bs,
                       input logic rd, input logic ov);
    chk({name, ".acc"},   32'(acc_a),  32'(acc));
    chk({name, ".done"},  32'(done_a), 32'(dn));
    chk({name, ".busy"},  32'(busy_a), 32'(bs));
    chk({name, ".ready"}, 32'(rdy_a),  32'(rd));
    chk({name, ".ovf"},   32'(ovf_a),  32'(ov));
  endtask

  logic [3:0]  plist[8];
  int          gaps[8];
  logic [11:0] run;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; prod = 4'd0;

    // Test 1 vectors: start, eight products of 9, start attempts during ACC and DONE.
    tbl[0] = '{1, 0, 0, 4'd0, 12'd0,  0, 1, 1, 0};
    tbl[1] = '{0, 0, 1, 4'd9, 12'd9,  0, 1, 1, 0};
    tbl[2] = '{0, 0, 1, 4'd9, 12'd18, 0, 1, 1, 0};
    tbl[3] = '{0, 0, 1, 4'd9, 12'd27, 0, 1, 1, 0};
    tbl[4] = '{1, 0, 1, 4'd9, 12'd36, 0, 1, 1, 0};
    tbl[5] = '{0, 0, 1, 4'd9, 12'd45, 0, 1, 1, 0};
    tbl[6] = '{0, 0, 1, 4'd9, 12'd54, 0, 1, 1, 0};
    tbl[7] = '{0, 0, 1, 4'd9, 12'd63, 0, 1, 1, 0};
    tbl[8] = '{0, 0, 1, 4'd9, 12'd72, 1, 0, 0, 0};
    tbl[9] = '{1, 0, 0, 4'd0, 12'd72, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 4'd0, 12'd72, 0, 0, 0, 0};

    plist = '{4'd1, 4'd6, 4'd2, 4'd9, 4'd0, 4'd3, 4'd4, 4'd6};
    gaps  = '{0, 1, 3, 2, 0, 1, 2, 3};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_a("reset", 12'd0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: back-to-back 9s; the AW=6 instance sees the same stream and wraps.
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].st, tbl[i].ab, tbl[i].vl, tbl[i].pr);
      chk_a($sformatf("t1[%0d]", i), tbl[i].acc, tbl[i].dn, tbl[i].bs, tbl[i].rd, tbl[i].ov);
    end
    chk("t3.acc_w", 32'(acc_w), 32'd8);
    chk("t3.ovf_w", 32'(ovf_w), 32'd1);

    // Test 2: products with gaps in in_valid.
    step(1, 0, 0, 4'd0);
    chk("t2.start.busy", 32'(busy_a), 32'd1);
    chk("t3.ovf_w_cleared", 32'(ovf_w), 32'd0);
    run = 12'd0;
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < gaps[k]; g++) begin
        step(0, 0, 0, 4'hF);
        chk($sformatf("t2.gap%0d.acc", k), 32'(acc_a), 32'(run));
        chk($sformatf("t2.gap%0d.done", k), 32'(done_a), 32'd0);
        chk($sformatf("t2.gap%0d.busy", k), 32'(busy_a), 32'd1);
      end
      step(0, 0, 1, plist[k]);
      run = run + 12'(plist[k]);
      chk($sformatf("t2.acc%0d", k), 32'(acc_a), 32'(run));
      chk($sformatf("t2.done%0d", k), 32'(done_a), (k == 7) ? 32'd1 : 32'd0);
      chk($sformatf("t2.busy%0d", k), 32'(busy_a), (k == 7) ? 32'd0 : 32'd1);
    end
    step(0, 0, 0, 4'd0);
    chk_a("t2.end", 12'd31, 0, 0, 0, 0);
    chk("t2.ovf_w", 32'(ovf_w), 32'd0);

    // Test 4: abort together with the 5th valid product, then a full job of 4s.
    step(1, 0, 0, 4'd0);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 4'd5);
    chk("t4.pre_abort.acc", 32'(acc_a), 32'd20);
    step(0, 1, 1, 4'd5);
    chk_a("t4.abort", 12'd0, 0, 0, 0, 0);
    step(0, 0, 0, 4'd0);
    chk_a("t4.after_abort", 12'd0, 0, 0, 0, 0);
    step(1, 0, 0, 4'd0);
    for (int k = 0; k < 8; k++) step(0, 0, 1, 4'd4);
    chk_a("t4.fours", 12'd32, 1, 0, 0, 0);
    step(0, 0, 0, 4'd0);
    chk_a("t4.idle", 12'd32, 0, 0, 0, 0);
    // Valid product while IDLE is not accepted.
    step(0, 0, 1, 4'd7);
    chk_a("t6.idle_valid", 12'd32, 0, 0, 0, 0);

    // Test 5: asynchronous reset between edges mid-job.
    step(1, 0, 0, 4'd0);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 4'd9);
    chk("t5.pre_rst.acc", 32'(acc_a), 32'd27);
    #2 rst = 1'b1;
    #1;
    chk_a("t5.async_rst", 12'd0, 0, 0, 0, 0);
    rst = 1'b0;
    step(0, 0, 1, 4'd9);
    chk_a("t5.after_rst", 12'd0, 0, 0, 0, 0);

    // Test 6: N=1 instance.
    step(1, 0, 0, 4'd0);
    chk("t6.n1.busy", 32'(busy_n), 32'd1);
    step(0, 0, 1, 4'd6);
    chk("t6.n1.done", 32'(done_n), 32'd1);
    chk("t6.n1.acc", 32'(acc_n), 32'd6);
    step(0, 0, 0, 4'd0);
    chk("t6.n1.done_off", 32'(done_n), 32'd0);
    chk("t6.n1.acc_hold", 32'(acc_n), 32'd6);
    step(0, 0, 1, 4'd3);
    chk("t6.n1.idle_valid", 32'(acc_n), 32'd6);
    chk("t6.n1.ready", 32'(rdy_n), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
